instr_encoder: RTL
==================

# instr_encoder

- Inverse of the instruction decoder: takes decoded RV64IM fields and reassembles them into a 32-bit instruction word.
- Sits between the test/trace generator (or a future micro-op replay path) and any consumer of raw instruction words, such as the fetch-side instruction buffer.
- Inputs are accepted through a valid/ready handshake and encoded combinationally. Results are buffered in an output FIFO with their own valid/ready handshake.
- Field legality (immediate range/alignment, opcode) is optionally checked.

## Interface
- `INSTR_WIDTH`, 32: output instruction width.
- `DATA_WIDTH`, 64: immediate input width.
- `ALU_OP_WIDTH` / `ALU_FUNC3_WIDTH` / `ALU_FUNC7_WIDTH` / `REG_ID_WIDTH`, 7/3/7/5: field widths.
- `FIFO_DEPTH`, 4: output buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `flush`  in  1  synchronous clear of buffered entries.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  encoder can accept.
- `alu_op`, `func3`, `func7`  in  7/3/7  opcode and function fields.
- `imm`  in  64  sign-extended immediate, same convention the decoder produces.
- `rs1`, `rs2`, `rd`  in  5 each  register ids.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes head.
- `out_instr`  out  32  encoded instruction at head.
- `out_err`  out  1  head entry failed legality check.

## Operation
Encoding, by opcode group (bit ranges shown msb→lsb):
- R-type (0110011, 0111011): `func7 | rs2 | rs1 | func3 | rd | op`.
- I-ALU (0010011, 0011011):
  - Shifts (`func3` = 001/101): `func7 | imm[4:0] | rs1 | func3 | rd | op`.
  - Otherwise: `imm[11:0] | rs1 | func3 | rd | op`.
- Load, JALR (0000011, 1100111), SYSTEM (1110011): `imm[11:0] | rs1 | func3 | rd | op`.
- S (0100011): `imm[11:5] | rs2 | rs1 | func3 | imm[4:0] | op`.
- B (1100011): `imm[12] | imm[10:5] | rs2 | rs1 | func3 | imm[4:1] | imm[11] | op`.
- J (1101111): `imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | op`.
- U (0110111, 0010111): `imm[31:12] | rd | op`.
- Unlisted opcode: illegal.

Handshake and buffering:
- Transfer occurs when `in_valid && in_ready`. The encoded word and its error bit are pushed into the FIFO on that edge.
- `in_ready = !full`. A full FIFO accepts nothing, even when a pop happens in the same cycle (no pass-through).
- Pop occurs when `out_valid && out_ready`.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves the occupancy unchanged.
- `out_instr` and `out_err` are driven from the FIFO head. Both are 0 when the FIFO is empty.
- `flush` empties the FIFO and drops any same-cycle push. `reset_n` low has priority over `flush`.
- Pointers wrap modulo `FIFO_DEPTH`. A separate count of width clog2(`FIFO_DEPTH`)+1 distinguishes full from empty.

## Timing
- Reset values: `out_valid`=0, `out_instr`=0, `out_err`=0, `in_ready`=1, pointers and count 0.
- Latency: a bundle accepted at edge N appears at the head (`out_valid`=1) from edge N+1 when the FIFO was empty. Otherwise it appears behind earlier entries in order.
- Throughput: one instruction per cycle while not full and `out_ready` is high.
- Reset asserted mid-stream discards all entries. `in_ready` rises in the first cycle after reset deasserts.
- `out_valid`/`out_instr` stay stable while `out_ready` is low.

## Configuration
- `INSTR_ENCODER_CHECK_EN` defined — legality checks are compiled in:
  - I / S / Load / JALR / SYSTEM: `imm[63:11]` must all be equal.
  - B: `imm[63:12]` all equal and `imm[0]`=0.
  - J: `imm[63:20]` all equal and `imm[0]`=0.
  - U: `imm[63:31]` all equal and `imm[11:0]`=0.
  - Shifts: `imm[63:5]`=0.
  - Opcode must be in the list above.
  - On failure the stored word is 0x00000013 (nop) with `out_err`=1. The entry still consumes a FIFO slot.
- Macro undefined: no checks. Fields are truncated per the bit ranges above, unlisted opcodes encode as R-type, and `out_err` is tied 0.

## Structure
- Shared package `riscv_pkg`: opcode localparams (`OP_R`, `OP_R_W`, `OP_I`, `OP_I_W`, `OP_LOAD`, `OP_JALR`, `OP_STORE`, `OP_BRANCH`, `OP_JAL`, `OP_LUI`, `OP_AUIPC`, `OP_SYSTEM`), a format enum (R/I/S/B/J/U/ILLEGAL), and the `NOP_INSTR` constant. The decoder is to be migrated to the same package.
- One sub-module, `sync_fifo`, parameterized on width (33: `out_err` plus `out_instr`) and depth, containing the pointers, count and storage.
- Encode logic lives in the top level as a single `always_comb`.

## Test plan
- add x3,x1,x2 (op 0110011, all fields zero except rs1=1, rs2=2, rd=3), `out_ready`=1 → `out_instr`=0x002081B3 one cycle later, `out_err`=0.
- addi x1,x0,-1 (imm=0xFFFF_FFFF_FFFF_FFFF) → 0xFFF00093. sd x2,8(x1) → 0x0020B423.
- beq x0,x0,-4 → 0xFE000EE3. jal with imm=3 and check macro on → 0x00000013 with `out_err`=1. Same stimulus with macro off → `out_err`=0.
- `FIFO_DEPTH`=4, `out_ready`=0, five back-to-back valids → four accepted and `in_ready`=0 after the fourth. Raise `out_ready` → four words drained in order, with `in_ready`=1 the cycle after the first pop.
- Push and pop in the same cycle at occupancy 2 → occupancy stays 2 and order is preserved. `flush` with 3 entries plus a concurrent push → `out_valid`=0 on the next cycle.
- `reset_n` low for one cycle with 2 entries buffered → all outputs at reset values next cycle, and the first new push appears normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64IM encoding definitions: opcodes, instruction formats and the canonical nop.
// Intended to be shared by the decoder and instr_encoder.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_R_W    = 7'b0111011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_I_W    = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_U,
    FMT_ILLEGAL
  } fmt_e;

  // Load, JALR and SYSTEM share the I-type layout with the ALU immediates.
  function automatic fmt_e opcode_format(input logic [6:0] op);
    fmt_e fmt;
    case (op)
      OP_R, OP_R_W:                                fmt = FMT_R;
      OP_I, OP_I_W, OP_LOAD, OP_JALR, OP_SYSTEM:   fmt = FMT_I;
      OP_STORE:                                    fmt = FMT_S;
      OP_BRANCH:                                   fmt = FMT_B;
      OP_JAL:                                      fmt = FMT_J;
      OP_LUI, OP_AUIPC:                            fmt = FMT_U;
      default:                                     fmt = FMT_ILLEGAL;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers and a separate occupancy count.
// Head data reads as zero while empty; push on full and pop on empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; empty masks stale contents at the head.
  always_ff @(posedge clk) begin
    if (reset_n && push_ok) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_encoder.sv
// Reassembles decoded RV64IM fields into 32-bit instruction words, buffered in a FIFO.
// Define INSTR_ENCODER_CHECK_EN to compile in immediate/opcode legality checks.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int INSTR_WIDTH     = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int ALU_OP_WIDTH    = 7,
  parameter int ALU_FUNC3_WIDTH = 3,
  parameter int ALU_FUNC7_WIDTH = 7,
  parameter int REG_ID_WIDTH    = 5,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ALU_OP_WIDTH-1:0]    alu_op,
  input  logic [ALU_FUNC3_WIDTH-1:0] func3,
  input  logic [ALU_FUNC7_WIDTH-1:0] func7,
  input  logic [DATA_WIDTH-1:0]      imm,
  input  logic [REG_ID_WIDTH-1:0]    rs1,
  input  logic [REG_ID_WIDTH-1:0]    rs2,
  input  logic [REG_ID_WIDTH-1:0]    rd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_WIDTH-1:0]     out_instr,
  output logic                       out_err
);

  // Handshake: a bundle transfers on a rising edge with in_valid && in_ready, and
  // the head leaves on a rising edge with out_valid && out_ready. Neither ready
  // depends on the matching valid; a full FIFO never passes a push through a pop.

  fmt_e                   fmt;
  logic                   is_shift;
  logic [INSTR_WIDTH-1:0] enc_word;
  logic                   enc_err;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic [INSTR_WIDTH:0]   head;

`ifdef INSTR_ENCODER_CHECK_EN
  logic imm_bad;
`else
  logic unused_imm;
  assign unused_imm = ^imm[DATA_WIDTH-1:INSTR_WIDTH];
`endif

  always_comb begin
    fmt      = opcode_format(alu_op);
    is_shift = ((alu_op == OP_I) || (alu_op == OP_I_W)) &&
               ((func3 == 3'b001) || (func3 == 3'b101));
    enc_word = {func7, rs2, rs1, func3, rd, alu_op};
    enc_err  = 1'b0;
    case (fmt)
      FMT_I: begin
        if (is_shift) enc_word = {func7, imm[4:0], rs1, func3, rd, alu_op};
        else          enc_word = {imm[11:0], rs1, func3, rd, alu_op};
      end
      FMT_S:   enc_word = {imm[11:5], rs2, rs1, func3, imm[4:0], alu_op};
      FMT_B:   enc_word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], alu_op};
      FMT_J:   enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, alu_op};
      FMT_U:   enc_word = {imm[31:12], rd, alu_op};
      default: enc_word = {func7, rs2, rs1, func3, rd, alu_op};
    endcase
`ifdef INSTR_ENCODER_CHECK_EN
    // Immediates must be sign-extensions of what the field can hold.
    imm_bad = 1'b0;
    case (fmt)
      FMT_I: begin
        if (is_shift) imm_bad = |imm[DATA_WIDTH-1:5];
        else          imm_bad = !((&imm[DATA_WIDTH-1:11]) || !(|imm[DATA_WIDTH-1:11]));
      end
      FMT_S:   imm_bad = !((&imm[DATA_WIDTH-1:11]) || !(|imm[DATA_WIDTH-1:11]));
      FMT_B:   imm_bad = !((&imm[DATA_WIDTH-1:12]) || !(|imm[DATA_WIDTH-1:12])) || imm[0];
      FMT_J:   imm_bad = !((&imm[DATA_WIDTH-1:20]) || !(|imm[DATA_WIDTH-1:20])) || imm[0];
      FMT_U:   imm_bad = !((&imm[DATA_WIDTH-1:31]) || !(|imm[DATA_WIDTH-1:31])) || (|imm[11:0]);
      FMT_ILLEGAL: imm_bad = 1'b1;
      default: imm_bad = 1'b0;
    endcase
    if (imm_bad) begin
      enc_word = NOP_INSTR;
      enc_err  = 1'b1;
    end
`endif
  end

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_err   = head[INSTR_WIDTH];
  assign out_instr = head[INSTR_WIDTH-1:0];

  sync_fifo #(
    .WIDTH (INSTR_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (push),
    .push_data ({enc_err, enc_word}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (head)
  );

endmodule
